// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared frame-length helper and bit-order constants for the deserializer
//
// Purpose: constants and helpers shared by both ends of a serial link so the
//          serializer and the deserializer agree on frame length and bit order.
// Contents:
//   ORDER_LSB_FIRST / ORDER_MSB_FIRST  bit-order selector values
//   frame_len(sel_width)               frame length N = 2**sel_width bits
package demux_pkg;

    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;

    function automatic int frame_len(input int sel_width);
        return 1 << sel_width;
    endfunction

endpackage

// File: rtl/demux_slot_cnt.sv
// rtl/demux_slot_cnt.sv - wrapping slot counter with enable, synchronous clear and last-slot flag
//
// Purpose: SEL_WIDTH-bit counter that walks the slots of one frame and wraps
//          naturally; shared by serializer (mux select) and deserializer.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-high reset
//   en_i    advance one slot
//   clr_i   synchronous clear to slot 0, wins over en_i
//   cnt_o   current slot index (registered)
//   last_o  high when cnt_o is the final slot of the frame
module demux_slot_cnt #(
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [SEL_WIDTH-1:0] cnt_o,
    output logic                 last_o
);

    logic [SEL_WIDTH-1:0] cnt_q;
    logic [SEL_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wraps from N-1 to 0 by plain overflow.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;

endmodule

// File: rtl/demux_deser.sv
// rtl/demux_deser.sv - registered serial-to-parallel demultiplexer with one-cycle valid pulse
//
// Purpose: collects one serial bit per enabled cycle into a shadow register and
//          publishes the completed N-bit word on a registered output.
// Parameters:
//   SEL_WIDTH  slot-index width, frame length N = 2**SEL_WIDTH
//   MSB_FIRST  0: first bit lands in bit 0, 1: first bit lands in bit N-1
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-high reset
//   demux_IN     serial data bit
//   demux_EN     bit-valid strobe
//   demux_CLR    synchronous frame abort
//   demux_OUT    last completed word (registered)
//   demux_VALID  one-cycle pulse when demux_OUT updates
//   demux_BUSY   partial frame held (demux_CNT != 0)
//   demux_CNT    index of the next slot to be written
module demux_deser
    import demux_pkg::*;
#(
    parameter int SEL_WIDTH = 2,
    parameter int MSB_FIRST = ORDER_LSB_FIRST
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            demux_IN,
    input  logic                            demux_EN,
    input  logic                            demux_CLR,
    output logic [frame_len(SEL_WIDTH)-1:0] demux_OUT,
    output logic                            demux_VALID,
    output logic                            demux_BUSY,
    output logic [SEL_WIDTH-1:0]            demux_CNT
);

    localparam int N = frame_len(SEL_WIDTH);

    logic [SEL_WIDTH-1:0] cnt;
    logic                 last_slot;
    logic [SEL_WIDTH-1:0] slot;
    logic [N-1:0]         slot_onehot;
    logic [N-1:0]         merged;

    logic [N-1:0] shadow_q, shadow_d;
    logic [N-1:0] out_q, out_d;
    logic         valid_q, valid_d;

    demux_slot_cnt #(
        .SEL_WIDTH(SEL_WIDTH)
    ) u_slot_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (demux_EN),
        .clr_i (demux_CLR),
        .cnt_o (cnt),
        .last_o(last_slot)
    );

    always_comb begin
        // N-1-cnt equals the bitwise inverse of cnt because N is a power of two.
        slot        = (MSB_FIRST == ORDER_MSB_FIRST) ? ~cnt : cnt;
        slot_onehot = N'(1) << slot;
        // Shadow with the incoming bit already placed, so the final bit can be
        // published on the same edge it arrives.
        merged      = demux_IN ? (shadow_q | slot_onehot) : (shadow_q & ~slot_onehot);
    end

    always_comb begin
        shadow_d = shadow_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        if (demux_CLR) begin
            shadow_d = '0;
        end else if (demux_EN) begin
            if (last_slot) begin
                out_d    = merged;
                valid_d  = 1'b1;
                // Cleared so unwritten slots of the next frame read as zero.
                shadow_d = '0;
            end else begin
                shadow_d = merged;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end

    assign demux_OUT   = out_q;
    assign demux_VALID = valid_q;
    assign demux_CNT   = cnt;
    assign demux_BUSY  = (cnt != '0);

endmodule

// File: tb/tb_demux_deser.sv
// tb/tb_demux_deser.sv - scoreboard bench for demux_deser in both bit orders
module tb_demux_deser;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       demux_IN = 1'b0;
    logic       demux_EN = 1'b0;
    logic       demux_CLR = 1'b0;

    logic [3:0] out_l, out_m;
    logic       valid_l, valid_m;
    logic       busy_l, busy_m;
    logic [1:0] cnt_l, cnt_m;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q_l[$];
    logic [3:0] exp_q_m[$];

    always #5 CLK = ~CLK;

    demux_deser #(.SEL_WIDTH(2), .MSB_FIRST(0)) dut_l (
        .CLK(CLK), .RST(RST), .demux_IN(demux_IN), .demux_EN(demux_EN),
        .demux_CLR(demux_CLR), .demux_OUT(out_l), .demux_VALID(valid_l),
        .demux_BUSY(busy_l), .demux_CNT(cnt_l)
    );

    demux_deser #(.SEL_WIDTH(2), .MSB_FIRST(1)) dut_m (
        .CLK(CLK), .RST(RST), .demux_IN(demux_IN), .demux_EN(demux_EN),
        .demux_CLR(demux_CLR), .demux_OUT(out_m), .demux_VALID(valid_m),
        .demux_BUSY(busy_m), .demux_CNT(cnt_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every VALID pulse must match the oldest pushed word.
    always @(negedge CLK) begin
        if (valid_l === 1'b1) begin
            if (exp_q_l.size() == 0) chk("lsb_unexpected_valid", 1, 0);
            else chk("lsb_word", {28'd0, out_l}, {28'd0, exp_q_l.pop_front()});
        end
        if (valid_m === 1'b1) begin
            if (exp_q_m.size() == 0) chk("msb_unexpected_valid", 1, 0);
            else chk("msb_word", {28'd0, out_m}, {28'd0, exp_q_m.pop_front()});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // s[0] is the first bit on the wire.
    task automatic send_frame(input bit s[4], input int gap);
        logic [3:0] wl, wm;
        for (int i = 0; i < 4; i++) begin
            wl[i]     = s[i];
            wm[3 - i] = s[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(gap);
            if (i == 3) begin
                exp_q_l.push_back(wl);
                exp_q_m.push_back(wm);
            end
            demux_IN = s[i];
            demux_EN = 1'b1;
            @(posedge CLK);
            #1;
            demux_EN = 1'b0;
            chk("cnt_step", {30'd0, cnt_l}, (i + 1) % 4);
            chk("busy_step", {31'd0, busy_l}, {31'd0, ((i + 1) % 4) != 0});
            chk("valid_step", {31'd0, valid_l}, {31'd0, i == 3});
        end
    endtask

    task automatic send_bits(input int n, input bit b);
        for (int i = 0; i < n; i++) begin
            demux_IN = b;
            demux_EN = 1'b1;
            @(posedge CLK);
            #1;
            demux_EN = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        chk("rst_out", {28'd0, out_l}, 0);
        chk("rst_valid", {31'd0, valid_l}, 0);
        chk("rst_cnt", {30'd0, cnt_l}, 0);
        chk("rst_busy", {31'd0, busy_l}, 0);
        RST = 1'b0;
        idle(1);

        // First frame gives a nonzero OUT so the async reset has work to do.
        send_frame('{1, 0, 1, 1}, 0);
        idle(1);
        chk("frame1_out", {28'd0, out_l}, 4'b1101);

        // Async reset mid-cycle, mid-frame, with EN held high.
        send_bits(2, 1'b1);
        demux_IN = 1'b1;
        demux_EN = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        chk("arst_out", {28'd0, out_l}, 0);
        chk("arst_cnt", {30'd0, cnt_l}, 0);
        chk("arst_busy", {31'd0, busy_l}, 0);
        chk("arst_valid", {31'd0, valid_l}, 0);
        chk("arst_out_m", {28'd0, out_m}, 0);
        idle(2);
        demux_EN = 1'b0;
        RST = 1'b0;
        idle(1);

        send_frame('{1, 0, 1, 1}, 0);
        idle(1);
        chk("post_rst_out", {28'd0, out_l}, 4'b1101);
        chk("post_rst_cnt", {30'd0, cnt_l}, 0);

        // Bit order.
        send_frame('{1, 0, 0, 0}, 0);
        idle(1);
        chk("order_lsb", {28'd0, out_l}, 4'b0001);
        chk("order_msb", {28'd0, out_m}, 4'b1000);

        // Gapped enable.
        send_frame('{1, 1, 1, 0}, 3);
        idle(2);
        chk("gap_out", {28'd0, out_l}, 4'b0111);

        // Back-to-back frames with EN continuous.
        send_frame('{1, 0, 0, 1}, 0);
        chk("b2b_out1", {28'd0, out_l}, 4'b1001);
        send_frame('{0, 1, 1, 0}, 0);
        chk("b2b_out2", {28'd0, out_l}, 4'b0110);
        idle(1);

        // Abort mid-frame.
        send_bits(2, 1'b1);
        demux_CLR = 1'b1;
        demux_EN  = 1'b1;
        demux_IN  = 1'b1;
        @(posedge CLK);
        #1;
        demux_CLR = 1'b0;
        demux_EN  = 1'b0;
        chk("abort_cnt", {30'd0, cnt_l}, 0);
        chk("abort_busy", {31'd0, busy_l}, 0);
        chk("abort_out", {28'd0, out_l}, 4'b0110);
        chk("abort_valid", {31'd0, valid_l}, 0);
        send_frame('{0, 0, 0, 0}, 0);
        idle(1);
        chk("no_stale_l", {28'd0, out_l}, 4'b0000);
        chk("no_stale_m", {28'd0, out_m}, 4'b0000);

        // CLR on the final slot drops the frame.
        send_frame('{1, 0, 1, 0}, 1);
        idle(1);
        send_bits(3, 1'b1);
        demux_CLR = 1'b1;
        demux_EN  = 1'b1;
        demux_IN  = 1'b1;
        @(posedge CLK);
        #1;
        demux_CLR = 1'b0;
        demux_EN  = 1'b0;
        chk("clr_last_valid", {31'd0, valid_l}, 0);
        chk("clr_last_cnt", {30'd0, cnt_l}, 0);
        chk("clr_last_out", {28'd0, out_l}, 4'b0101);
        chk("clr_last_out_m", {28'd0, out_m}, 4'b1010);
        idle(3);

        chk("sb_drain_l", exp_q_l.size(), 0);
        chk("sb_drain_m", exp_q_m.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_deser.md
Name: demux_deser

Overview:
- Registered serial-to-parallel demultiplexer: the receive-side counterpart of the team's registered bit-select mux.
- Captures one serial bit per enabled cycle into slot `demux_CNT` of a 2**SEL_WIDTH-bit shadow register. The slot index is generated internally.
- Publishes the completed word on a registered parallel output with a one-cycle valid pulse.
- Sits at the far end of any link driven by the mux-based serializer.

Parameters:
- SEL_WIDTH, 2, slot-index width; frame length N = 2**SEL_WIDTH bits.
- MSB_FIRST, 0, 0: first received bit lands in bit 0; 1: first received bit lands in bit N-1.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- demux_IN  input  1  serial data bit
- demux_EN  input  1  bit-valid strobe; demux_IN is sampled only when high
- demux_CLR  input  1  synchronous frame abort; restarts the frame
- demux_OUT  output  N  last completed parallel word (registered)
- demux_VALID  output  1  one-cycle pulse when demux_OUT updates
- demux_BUSY  output  1  high while a partial frame is held (demux_CNT != 0)
- demux_CNT  output  SEL_WIDTH  index of the next slot to be written

Behaviour:
- Reset (RST high, async, dominant over everything):
  - demux_OUT = 0, demux_VALID = 0, demux_CNT = 0, demux_BUSY = 0.
  - Shadow register = 0.
  - Deasserting RST mid-frame discards the partial frame; the next enabled bit goes to slot 0.
- Slot mapping: physical bit = demux_CNT when MSB_FIRST=0; N-1-demux_CNT when MSB_FIRST=1.
- Enabled cycle (EN=1, CLR=0, demux_CNT < N-1):
  - Shadow[slot] <= demux_IN; demux_CNT <= demux_CNT+1; demux_VALID <= 0.
- Final bit (EN=1, CLR=0, demux_CNT == N-1):
  - demux_OUT <= shadow with the current demux_IN merged into its slot, in the same edge. No extra cycle.
  - demux_VALID <= 1 for exactly one cycle.
  - demux_CNT wraps to 0 (natural SEL_WIDTH overflow); shadow <= 0.
- Latency: demux_OUT and demux_VALID are visible the cycle after the final enabled bit.
- Back-to-back frames: EN may stay high continuously. Throughput is one word per N cycles and VALID pulses every N cycles with no gap.
- Idle (EN=0, CLR=0): all state holds; demux_VALID <= 0.
- demux_CLR=1:
  - demux_CNT <= 0; shadow <= 0; demux_VALID <= 0.
  - demux_OUT holds its last completed word.
  - CLR beats a simultaneous EN; that bit is dropped, even on the final slot (no VALID, OUT unchanged).
- demux_BUSY is combinational from the demux_CNT register (demux_CNT != 0). No input-to-output combinational paths.
- Unwritten shadow bits are always 0, so an aborted frame never leaks stale bits into a later word.

Decomposition:
- Shared package (demux_pkg):
  - Frame-length function N(SEL_WIDTH) = 1 << SEL_WIDTH.
  - Bit-order constants LSB_FIRST=0 / MSB_FIRST=1, shared with the serializer side so both ends agree on ordering.
- One natural sub-module: demux_slot_cnt.
  - SEL_WIDTH-bit wrap counter with enable and synchronous clear.
  - Flags last-slot (count == N-1).
  - Reusable by the transmit-side serializer to drive mux_SEL.
- Top level: shadow register, slot decode, output register.

Test Plan:
- Reset check: assert RST asynchronously mid-cycle with EN=1 -> all outputs 0 immediately. After release, bits 1,0,1,1 (EN continuous, MSB_FIRST=0) -> demux_OUT=4'b1101, VALID high one cycle, demux_CNT=0.
- Bit order: MSB_FIRST=1, bits 1,0,0,0 -> demux_OUT=4'b1000. Same stream with MSB_FIRST=0 -> 4'b0001.
- Gapped enable: bits 1,1,1,0 with EN low for 3 cycles between each bit -> demux_CNT steps 0,1,2,3, BUSY high from bit 1 until wrap, single VALID, OUT=4'b0111.
- Back-to-back: EN high 8 cycles, stream 1,0,0,1,0,1,1,0 -> VALID on cycles 5 and 9, OUT=4'b1001 then 4'b0110.
- Abort: 2 bits (1,1), then CLR=1 with EN=1 -> CNT=0, BUSY=0, OUT keeps previous word. Next frame 0,0,0,0 -> OUT=4'b0000 (no stale 1s).
- CLR on final slot: 3 bits, then CLR=1 with EN=1 on the 4th -> no VALID, OUT unchanged, CNT=0.
